// File: rtl/instr_issue_unit.sv
// Instruction issue unit: fetches one word at a time, holds it for the
// consumer, then resolves the next pc from the redirect inputs on accept.
module instr_issue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        link_wr,
    output logic [31:0] link_data,
    output logic        halted,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        accept;
    logic        fetch_done;

    assign pc4    = instr_pc + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        priority case (1'b1)
            jr:             next_pc = {jr_target[31:2], 2'b00};
            (jump | jal):   next_pc = {pc4[31:28], instr[25:0], 2'b00};
            (branch & zero): next_pc = pc4 + br_off;
            default:        next_pc = pc4;
        endcase
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        accept      = 1'b0;
        fetch_done  = 1'b0;
        case (state)
            FETCH: begin
                // held low while reset is asserted so the request drops at once
                imem_req   = rst_n;
                fetch_done = imem_ack;
                if (imem_ack) state_nx = HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                accept      = instr_ready;
                if (instr_ready) begin
                    state_nx = (instr[31:26] == HALT_OP) ? HALT : FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nx = FETCH;
        endcase
    end

    assign imem_addr = {pc[31:2], 2'b00};
    assign opcode    = instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            link_wr     <= 1'b0;
            link_data   <= 32'd0;
            issue_count <= 16'd0;
        end else begin
            state   <= state_nx;
            link_wr <= 1'b0;
            if (fetch_done) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (accept) begin
                pc          <= next_pc;
                issue_count <= issue_count + 16'd1;
                if (jal) begin
                    link_wr   <= 1'b1;
                    link_data <= pc4;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: stimulus queues expected fetches,
// issues and link writes; a negedge monitor pops and compares them.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        jal = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        link_wr;
    logic [31:0] link_data;
    logic        halted;
    logic [15:0] issue_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] fq[$];
    logic [63:0] iq[$];
    logic [31:0] lq[$];
    time         acc_t[$];

    instr_issue_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .opcode(opcode),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .branch(branch),
        .zero(zero),
        .jump(jump),
        .jal(jal),
        .jr(jr),
        .jr_target(jr_target),
        .link_wr(link_wr),
        .link_data(link_data),
        .halted(halted),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compares every observed handshake against the queues
    always @(negedge clk) begin
        if (imem_req && imem_ack) begin
            if (fq.size() == 0) chk("fetch_unexpected", imem_addr, 32'hx);
            else chk("fetch_addr", imem_addr, fq.pop_front());
        end
        if (instr_valid && instr_ready) begin
            acc_t.push_back($time);
            if (iq.size() == 0) begin
                chk("issue_unexpected", instr, 32'hx);
            end else begin
                logic [63:0] e;
                e = iq.pop_front();
                chk("issue_instr", instr, e[63:32]);
                chk("issue_pc", instr_pc, e[31:0]);
                chk("issue_opcode", {26'd0, opcode}, {26'd0, e[63:58]});
            end
        end
        if (link_wr) begin
            if (lq.size() == 0) chk("link_unexpected", link_data, 32'hx);
            else chk("link_data", link_data, lq.pop_front());
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] w,
                         input int ad, input int rd,
                         input logic br, input logic zr, input logic jp,
                         input logic jl, input logic jrr,
                         input logic [31:0] jt);
        logic [15:0] cnt;
        wait_req();
        fq.push_back(a);
        iq.push_back({w, a});
        if (jl) lq.push_back(a + 32'd4);
        for (int i = 0; i < ad; i++) begin
            @(posedge clk);
            #1;
            chk("addr_stable", imem_addr, a);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h5A5A_5A5A;
        cnt = issue_count;
        // redirect noise while not accepted must be ignored
        jr = 1'b1;
        jump = 1'b1;
        jr_target = 32'hDEAD_BEE0;
        for (int i = 0; i < rd; i++) begin
            @(posedge clk);
            #1;
            chk("hold_instr", instr, w);
            chk("hold_pc", instr_pc, a);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_cnt", {16'd0, issue_count}, {16'd0, cnt});
        end
        branch = br;
        zero = zr;
        jump = jp;
        jal = jl;
        jr = jrr;
        jr_target = jt;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        branch = 1'b0;
        zero = 1'b0;
        jump = 1'b0;
        jal = 1'b0;
        jr = 1'b0;
        jr_target = 32'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_pc"}, instr_pc, 32'd0);
        chk({tag, "_link"}, {31'd0, link_wr}, 32'd0);
        chk({tag, "_linkd"}, link_data, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, issue_count}, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst0");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);

        issue(32'h0, 32'h2008_0001, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h4, 32'h2009_0002, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_cnt", {16'd0, issue_count}, 32'd2);
        #2;
        if (acc_t.size() >= 2) chk("seq_rate", 32'(acc_t[1] - acc_t[0]), 32'd20);
        else chk("seq_rate_missing", acc_t.size(), 32'd2);

        issue(32'h8, 32'h0C00_0040, 3, 5, 0, 0, 0, 1, 0, 0);
        issue(32'h100, 32'h0000_0000, 0, 0, 0, 0, 1, 0, 1, 32'hC);
        issue(32'hC, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h10, 32'h1000_FFFF, 0, 0, 1, 1, 0, 0, 0, 0);
        issue(32'h10, 32'h1000_FFFF, 0, 0, 1, 0, 0, 0, 0, 0);
        issue(32'h14, 32'h0800_0003, 0, 0, 1, 1, 1, 0, 0, 0);
        issue(32'hC, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        issue(32'hFFFF_FFFC, 32'h0000_0000, 1, 1, 0, 0, 0, 0, 0, 0);
        issue(32'h0, 32'hFC00_0000, 0, 0, 0, 0, 0, 0, 0, 0);

        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_cnt", {16'd0, issue_count}, 32'd11);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_stay", {31'd0, halted}, 32'd1);
            chk("halt_instr", instr, 32'hFC00_0000);
        end
        imem_ack = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst1");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel1_addr", imem_addr, 32'd0);
        wait_req();
        fq.push_back(32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0001;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        chk("midhold_valid", {31'd0, instr_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst2");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel2_req", {31'd0, imem_req}, 32'd1);
        chk("rel2_addr", imem_addr, 32'd0);
        issue(32'h0, 32'h2009_0002, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_cnt", {16'd0, issue_count}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("fq_left", fq.size(), 32'd0);
        chk("iq_left", iq.size(), 32'd0);
        chk("lq_left", lq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
